ignition_seq: RTL and testbench

IGNITION_SEQ -- requirements
Module: ignition_seq

---
 rtl/car_pkg.sv | 25 ++
 rtl/tick_gen.sv | 30 +++
 rtl/ignition_seq.sv | 150 +++++++++++++++
 tb/tb_ignition_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared encodings for the ignition sequencer: FSM state codes, buzzer
// urgency classes and a counter-width helper.
package car_pkg;

    // FSM state codes, also visible on the debug state port
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_CRANK = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Buzzer urgency class
    typedef enum logic [1:0] {
        CLS_SILENT = 2'd0,
        CLS_SLOW   = 2'd1,
        CLS_FAST   = 2'd2
    } bz_class_t;

    // Bits needed to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running timing-tick divider: one-cycle tick every TICK_DIV clocks.
module tick_gen
    import car_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             W    = cnt_w(TICK_DIV);
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; never restarted except by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ignition_seq.sv
// Ignition sequencer: gates engine start on the legal checker's permit,
// times the starter crank, latches aborted starts and drives a warning chime.
module ignition_seq
    import car_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int CRANK_TICKS = 20,
    parameter int FAST_HALF   = 2,
    parameter int SLOW_HALF   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_permit,
    input  logic       warn_pr1,
    input  logic       warn_pr2,
    input  logic       key,
    input  logic       start_btn,
    output logic       crank,
    output logic       engine_on,
    output logic       fault,
    output logic       buzzer,
    output logic [1:0] state_o
);

    localparam int            CW         = cnt_w(CRANK_TICKS);
    localparam logic [CW-1:0] CRANK_LAST = CW'(CRANK_TICKS - 1);
    localparam int            PW         = cnt_w(SLOW_HALF);
    localparam logic [PW-1:0] FAST_LAST  = PW'(FAST_HALF - 1);
    localparam logic [PW-1:0] SLOW_LAST  = PW'(SLOW_HALF - 1);

    state_t        state;
    logic          btn_q;
    logic          start_ev;
    logic          tick;
    logic [CW-1:0] crank_cnt;
    bz_class_t     cls;
    bz_class_t     cls_q;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_last;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rising edge of the button only; a held button never retriggers
    assign start_ev = start_btn && !btn_q;
    assign state_o  = state;

    // Sequencer FSM with registered outputs, crank timing and button history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            crank     <= 1'b0;
            engine_on <= 1'b0;
            fault     <= 1'b0;
            crank_cnt <= '0;
            btn_q     <= 1'b0;
        end else begin
            btn_q <= start_btn;
            case (state)
                ST_OFF: begin
                    if (start_ev && start_permit && key) begin
                        state     <= ST_CRANK;
                        crank     <= 1'b1;
                        crank_cnt <= '0;
                    end
                end
                ST_CRANK: begin
                    // key removal wins over a dangerous warning
                    if (!key) begin
                        state <= ST_OFF;
                        crank <= 1'b0;
                    end else if (warn_pr1) begin
                        state <= ST_FAULT;
                        crank <= 1'b0;
                        fault <= 1'b1;
                    end else if (tick) begin
                        if (crank_cnt == CRANK_LAST) begin
                            state     <= ST_RUN;
                            crank     <= 1'b0;
                            engine_on <= 1'b1;
                        end else begin
                            crank_cnt <= crank_cnt + CW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!key) begin
                        state     <= ST_OFF;
                        engine_on <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (!key) begin
                        state <= ST_OFF;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    crank     <= 1'b0;
                    engine_on <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

    // Buzzer urgency class from live warnings and the latched fault state
    always_comb begin
        cls = CLS_SILENT;
        if (warn_pr1 || (state == ST_FAULT)) begin
            cls = CLS_FAST;
        end else if (warn_pr2) begin
            cls = CLS_SLOW;
        end
    end

    assign phase_last = (cls == CLS_FAST) ? FAST_LAST : SLOW_LAST;

    // Chime: restart high on every class change, then toggle each half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q  <= CLS_SILENT;
            phase  <= '0;
            buzzer <= 1'b0;
        end else begin
            cls_q <= cls;
            if (cls != cls_q) begin
                phase  <= '0;
                buzzer <= (cls != CLS_SILENT);
            end else if (cls == CLS_SILENT) begin
                phase  <= '0;
                buzzer <= 1'b0;
            end else if (tick) begin
                if (phase == phase_last) begin
                    phase  <= '0;
                    buzzer <= ~buzzer;
                end else begin
                    phase <= phase + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ignition_seq.sv
// Directed-vector bench for ignition_seq with a short timing configuration.
module tb_ignition_seq;

    logic clk;
    logic rst_n;
    logic start_permit;
    logic warn_pr1;
    logic warn_pr2;
    logic key;
    logic start_btn;
    logic crank;
    logic engine_on;
    logic fault;
    logic buzzer;
    logic [1:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    ignition_seq #(
        .TICK_DIV    (4),
        .CRANK_TICKS (3),
        .FAST_HALF   (1),
        .SLOW_HALF   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_permit (start_permit),
        .warn_pr1     (warn_pr1),
        .warn_pr2     (warn_pr2),
        .key          (key),
        .start_btn    (start_btn),
        .crank        (crank),
        .engine_on    (engine_on),
        .fault        (fault),
        .buzzer       (buzzer),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {crank, engine_on, fault, buzzer, state_o}
    logic [5:0] obs;
    assign obs = {crank, engine_on, fault, buzzer, state_o};

    typedef struct {
        logic       key;
        logic       permit;
        logic       btn;
        logic       w1;
        logic       w2;
        int         n;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic k, input logic p, input logic b,
                       input logic a1, input logic a2, input int n,
                       input logic [5:0] e);
        vec_t v;
        v.key = k; v.permit = p; v.btn = b; v.w1 = a1; v.w2 = a2;
        v.n = n; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (crank,engine_on,fault,buzzer,state)",
                     name, obs, exp);
        end
    endtask

    task automatic drive(input logic k, input logic p, input logic b,
                         input logic a1, input logic a2);
        key = k; start_permit = p; start_btn = b; warn_pr1 = a1; warn_pr2 = a2;
    endtask

    initial begin
        // Row timing assumes rows start right after reset release, tick at
        // every 4th edge; expected = {crank,eng,fault,buz,state[1:0]}
        //   key perm btn w1 w2 n    expected
        add(1, 1, 1, 0, 0,  1, 6'b1_0_0_0_01); // start edge -> CRANK
        add(1, 1, 1, 0, 0, 10, 6'b1_0_0_0_01); // held button, still cranking
        add(1, 1, 0, 0, 0,  1, 6'b0_1_0_0_10); // third tick -> RUN
        add(1, 1, 0, 0, 0,  3, 6'b0_1_0_0_10);
        add(1, 1, 0, 0, 1,  1, 6'b0_1_0_1_10); // pr2: buzzer high next cycle
        add(1, 1, 0, 0, 1, 11, 6'b0_1_0_1_10);
        add(1, 1, 0, 0, 1,  1, 6'b0_1_0_0_10); // toggles after 12 clk
        add(1, 1, 0, 0, 1, 11, 6'b0_1_0_0_10);
        add(1, 1, 0, 0, 1,  1, 6'b0_1_0_1_10);
        add(1, 1, 0, 0, 1, 12, 6'b0_1_0_0_10);
        add(1, 1, 0, 0, 1,  3, 6'b0_1_0_0_10);
        add(1, 1, 0, 1, 1,  1, 6'b0_1_0_1_10); // pr1 added: restart at 1
        add(1, 1, 0, 1, 1,  3, 6'b0_1_0_1_10);
        add(1, 1, 0, 1, 1,  1, 6'b0_1_0_0_10); // toggles after 4 clk
        add(1, 1, 0, 1, 1,  3, 6'b0_1_0_0_10);
        add(1, 1, 0, 1, 1,  1, 6'b0_1_0_1_10);
        add(0, 1, 0, 0, 0,  1, 6'b0_0_0_0_00); // key off -> OFF
        add(1, 0, 1, 0, 0,  1, 6'b0_0_0_0_00); // no permit: ignored
        add(1, 0, 0, 0, 0,  1, 6'b0_0_0_0_00);
        add(1, 0, 1, 0, 0,  2, 6'b0_0_0_0_00); // hold button
        add(1, 1, 1, 0, 0,  3, 6'b0_0_0_0_00); // permit rises while held
        add(1, 1, 0, 0, 0,  1, 6'b0_0_0_0_00);
        add(1, 1, 1, 0, 0,  1, 6'b1_0_0_0_01); // fresh edge -> CRANK
        add(1, 1, 0, 0, 0,  1, 6'b1_0_0_0_01);
        add(1, 1, 0, 1, 0,  1, 6'b0_0_1_1_11); // pr1 in CRANK -> FAULT
        add(1, 1, 0, 1, 0,  3, 6'b0_0_1_1_11);
        add(1, 1, 0, 1, 0,  1, 6'b0_0_1_0_11);
        add(1, 1, 0, 1, 0,  3, 6'b0_0_1_0_11);
        add(1, 1, 0, 1, 0,  1, 6'b0_0_1_1_11);
        add(1, 1, 0, 0, 0,  4, 6'b0_0_1_0_11); // FAULT alone keeps FAST
        add(0, 1, 0, 0, 0,  1, 6'b0_0_0_0_00); // key off clears fault
        add(0, 1, 0, 0, 0,  1, 6'b0_0_0_0_00);
        add(1, 1, 1, 0, 0,  1, 6'b1_0_0_0_01);
        add(0, 1, 1, 1, 0,  1, 6'b0_0_0_1_00); // key off beats pr1
        add(0, 1, 0, 0, 0,  1, 6'b0_0_0_0_00);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_state", 6'b0_0_0_0_00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].key, tbl[i].permit, tbl[i].btn, tbl[i].w1, tbl[i].w2);
            repeat (tbl[i].n) step();
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // Reset in the middle of cranking
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("rst_pre_crank", 6'b1_0_0_0_01);
        repeat (2) step();
        check("rst_pre_hold", 6'b1_0_0_0_01);
        #2;
        rst_n     = 1'b0;
        start_btn = 1'b0;
        #1;
        check("rst_async", 6'b0_0_0_0_00);
        repeat (2) step();
        check("rst_hold", 6'b0_0_0_0_00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("rst_no_restart", 6'b0_0_0_0_00);
        start_btn = 1'b1;
        step();
        check("rst_new_edge", 6'b1_0_0_0_01);
        repeat (10) step();
        check("rst_crank_hold", 6'b1_0_0_0_01);
        step();
        check("rst_run", 6'b0_1_0_0_10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
